// File: rtl/up_axi_master.sv
// Purpose: bridges single-beat up_* register requests onto an AXI4-Lite master port.
// Latency: 3 cycles request-to-ack with a zero-wait slave; aborts after 2^TIMEOUT_WIDTH-1 busy cycles.
// Backpressure: none toward up_*; requests on a busy channel (or in its ACK cycle) are dropped.
module up_axi_master #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int TIMEOUT_WIDTH = 5
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,

    input  logic                     up_wreq,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    output logic                     up_werr,

    input  logic                     up_rreq,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack,
    output logic                     up_rerr,

    output logic                     m_axi_awvalid,
    output logic [31:0]              m_axi_awaddr,
    input  logic                     m_axi_awready,

    output logic                     m_axi_wvalid,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    input  logic                     m_axi_wready,

    input  logic                     m_axi_bvalid,
    input  logic [1:0]               m_axi_bresp,
    output logic                     m_axi_bready,

    output logic                     m_axi_arvalid,
    output logic [31:0]              m_axi_araddr,
    input  logic                     m_axi_arready,

    input  logic                     m_axi_rvalid,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    output logic                     m_axi_rready
);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_ACK} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ACK} r_state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE    = TIMEOUT_WIDTH'(1);
    localparam logic [31:0]              ABORT_DATA = 32'hdeaddead;

    // Word address to AXI byte address: zero-padded above, two zero bits below.
    function automatic logic [31:0] byte_addr(input logic [ADDRESS_WIDTH-1:0] word);
        logic [31:0] a;
        a = '0;
        a[ADDRESS_WIDTH+1:2] = word;
        return a;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t                 w_state;
    w_state_t                 w_next;
    logic [TIMEOUT_WIDTH-1:0] w_cnt;
    logic                     w_busy;
    logic                     w_at_max;
    logic                     w_accept;
    logic                     w_abort;
    logic                     aw_done;
    logic                     wd_done;

    // A valid that is already low has completed its handshake on an earlier cycle.
    assign aw_done  = ~m_axi_awvalid | m_axi_awready;
    assign wd_done  = ~m_axi_wvalid  | m_axi_wready;
    assign w_busy   = (w_state == W_XFER) || (w_state == W_RESP);
    assign w_at_max = w_busy && (w_cnt == CNT_MAX);
    assign w_accept = (w_state == W_IDLE) && up_wreq;

    // Write next-state; a handshake completing in the last counted cycle beats the abort.
    always_comb begin
        w_next  = w_state;
        w_abort = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (up_wreq) begin
                    w_next = W_XFER;
                end
            end
            W_XFER: begin
                if (aw_done && wd_done) begin
                    w_next = W_RESP;
                end else if (w_at_max) begin
                    w_next  = W_ACK;
                    w_abort = 1'b1;
                end
            end
            W_RESP: begin
                if (m_axi_bvalid) begin
                    w_next = W_ACK;
                end else if (w_at_max) begin
                    w_next  = W_ACK;
                    w_abort = 1'b1;
                end
            end
            W_ACK: begin
                w_next = W_IDLE;
            end
            default: begin
                w_next = W_IDLE;
            end
        endcase
    end

    // Write state register.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Address/data/strobe are captured on accept and held until the next accept.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            m_axi_awaddr <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
        end else if (w_accept) begin
            m_axi_awaddr <= byte_addr(up_waddr);
            m_axi_wdata  <= up_wdata;
            m_axi_wstrb  <= 4'hf;
        end
    end

    // AW and W valids rise together and each falls after its own handshake or on abort.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else if (w_accept) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
        end else if (w_abort) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
        end else begin
            if (m_axi_awready) begin
                m_axi_awvalid <= 1'b0;
            end
            if (m_axi_wready) begin
                m_axi_wvalid <= 1'b0;
            end
        end
    end

    // Write timeout counter: cleared on accept, counts busy cycles, sticks at all-ones.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_cnt <= '0;
        end else if (w_accept) begin
            w_cnt <= '0;
        end else if (w_busy && (w_cnt != CNT_MAX)) begin
            w_cnt <= w_cnt + CNT_ONE;
        end
    end

    // bready and the ack pulse follow the registered state; werr only changes when entering ACK.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            m_axi_bready <= 1'b0;
            up_wack      <= 1'b0;
            up_werr      <= 1'b0;
        end else begin
            m_axi_bready <= (w_next == W_RESP);
            up_wack      <= (w_next == W_ACK);
            if (w_abort) begin
                up_werr <= 1'b1;
            end else if ((w_state == W_RESP) && m_axi_bvalid) begin
                up_werr <= |m_axi_bresp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                 r_state;
    r_state_t                 r_next;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic                     r_busy;
    logic                     r_at_max;
    logic                     r_accept;
    logic                     r_abort;

    assign r_busy   = (r_state == R_ADDR) || (r_state == R_DATA);
    assign r_at_max = r_busy && (r_cnt == CNT_MAX);
    assign r_accept = (r_state == R_IDLE) && up_rreq;

    // Read next-state; arready/rvalid in the last counted cycle still complete normally.
    always_comb begin
        r_next  = r_state;
        r_abort = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (up_rreq) begin
                    r_next = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_axi_arready) begin
                    r_next = R_DATA;
                end else if (r_at_max) begin
                    r_next  = R_ACK;
                    r_abort = 1'b1;
                end
            end
            R_DATA: begin
                if (m_axi_rvalid) begin
                    r_next = R_ACK;
                end else if (r_at_max) begin
                    r_next  = R_ACK;
                    r_abort = 1'b1;
                end
            end
            R_ACK: begin
                r_next = R_IDLE;
            end
            default: begin
                r_next = R_IDLE;
            end
        endcase
    end

    // Read state register.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // AR channel: address held from accept, valid drops after arready or on abort.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
        end else if (r_accept) begin
            m_axi_araddr  <= byte_addr(up_raddr);
            m_axi_arvalid <= 1'b1;
        end else if ((r_state == R_ADDR) && (m_axi_arready || r_abort)) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    // Read timeout counter: cleared on accept, counts busy cycles, sticks at all-ones.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_cnt <= '0;
        end else if (r_accept) begin
            r_cnt <= '0;
        end else if (r_busy && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // rready and ack follow the state; rdata/rerr update only when entering ACK and then hold.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            m_axi_rready <= 1'b0;
            up_rack      <= 1'b0;
            up_rerr      <= 1'b0;
            up_rdata     <= '0;
        end else begin
            m_axi_rready <= (r_next == R_DATA);
            up_rack      <= (r_next == R_ACK);
            if (r_abort) begin
                up_rerr  <= 1'b1;
                up_rdata <= ABORT_DATA;
            end else if ((r_state == R_DATA) && m_axi_rvalid) begin
                up_rerr  <= |m_axi_rresp;
                up_rdata <= m_axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_up_axi_master.sv
// Purpose: randomized scoreboard bench for up_axi_master against a configurable AXI-Lite slave.
// Latency: expected ack cycles come from the request cycle plus slave delays (or the timeout bound).
// Backpressure: the slave model stalls each channel by a per-transaction delay or forever.
module tb_up_axi_master;

    localparam int AW = 8;
    localparam int TW = 5;
    // Request in cycle c: busy from c+1, counter reaches all-ones 2^TW-1 cycles later, ack the cycle after.
    localparam int TMO_LAT = 1 + (2**TW - 1) + 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic          up_clk = 1'b0;
    logic          up_rstn = 1'b0;
    logic          up_wreq = 1'b0;
    logic [AW-1:0] up_waddr = '0;
    logic [31:0]   up_wdata = '0;
    logic          up_wack;
    logic          up_werr;
    logic          up_rreq = 1'b0;
    logic [AW-1:0] up_raddr = '0;
    logic [31:0]   up_rdata;
    logic          up_rack;
    logic          up_rerr;
    logic          m_axi_awvalid;
    logic [31:0]   m_axi_awaddr;
    logic          m_axi_awready = 1'b0;
    logic          m_axi_wvalid;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wready = 1'b0;
    logic          m_axi_bvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bready;
    logic          m_axi_arvalid;
    logic [31:0]   m_axi_araddr;
    logic          m_axi_arready = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic [31:0]   m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rready;

    up_axi_master #(.ADDRESS_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
        .up_wack(up_wack), .up_werr(up_werr),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
        .up_rack(up_rack), .up_rerr(up_rerr),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rready(m_axi_rready)
    );

    always #5 up_clk = ~up_clk;

    int cyc = 0;
    always @(posedge up_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboards: up-side acks, and AXI-side address/data beats.
    exp_t        wq[$];
    exp_t        rq[$];
    logic [31:0] awq[$];
    logic [31:0] wdq[$];
    logic [31:0] arq[$];
    logic        w_pending = 1'b0;
    logic        r_pending = 1'b0;

    // Slave behaviour for the current transaction of each channel.
    // Write hang: 0 none, 1 never accept AW/W, 2 never send B. Read hang: 0 none, 1 never arready, 2 never rvalid.
    int          sw_aw_lat = 0, sw_w_lat = 0, sw_b_lat = 0, sw_hang = 0;
    logic [1:0]  sw_bresp = 2'b00;
    int          sr_ar_lat = 0, sr_r_lat = 0, sr_hang = 0;
    logic [31:0] sr_rdata = '0;
    logic [1:0]  sr_rresp = 2'b00;

    function automatic logic [31:0] to_byte(input logic [AW-1:0] a);
        logic [31:0] r;
        r = 32'(a) * 4;
        return r;
    endfunction

    task automatic issue_write(input logic [AW-1:0] a, input logic [31:0] d, input int awl,
                               input int wl, input int bl, input int hang, input logic [1:0] br);
        exp_t e;
        up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        sw_aw_lat = awl; sw_w_lat = wl; sw_b_lat = bl; sw_hang = hang; sw_bresp = br;
        e.cyc  = (hang != 0) ? cyc + TMO_LAT : cyc + 3 + ((awl > wl) ? awl : wl) + bl;
        e.err  = (hang != 0) || (br != 2'b00);
        e.data = '0;
        wq.push_back(e);
        if (hang != 1) begin
            awq.push_back(to_byte(a));
            wdq.push_back(d);
        end
        w_pending = 1'b1;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input int arl, input int rl, input int hang,
                              input logic [31:0] rd, input logic [1:0] rr);
        exp_t e;
        up_rreq = 1'b1; up_raddr = a;
        sr_ar_lat = arl; sr_r_lat = rl; sr_hang = hang; sr_rdata = rd; sr_rresp = rr;
        e.cyc  = (hang != 0) ? cyc + TMO_LAT : cyc + 3 + arl + rl;
        e.err  = (hang != 0) || (rr != 2'b00);
        e.data = (hang != 0) ? 32'hdeaddead : rd;
        rq.push_back(e);
        if (hang != 1) arq.push_back(to_byte(a));
        r_pending = 1'b1;
    endtask

    // AXI-Lite slave model: readies/valids driven at the falling edge from the DUT's stable outputs.
    int   aw_age = 0, w_age = 0, b_age = 0, ar_age = 0, r_age = 0;
    logic aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    always @(negedge up_clk) begin
        logic [31:0] ex;
        if (!up_rstn) begin
            aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
            aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        end else begin
            if (aw_hs) check("awvalid_drop", 32'(m_axi_awvalid), 32'd0);
            if (w_hs)  check("wvalid_drop", 32'(m_axi_wvalid), 32'd0);
            if (b_hs)  check("bready_drop", 32'(m_axi_bready), 32'd0);
            if (ar_hs) check("arvalid_drop", 32'(m_axi_arvalid), 32'd0);
            if (r_hs)  check("rready_drop", 32'(m_axi_rready), 32'd0);

            aw_age = m_axi_awvalid ? aw_age + 1 : 0;
            m_axi_awready = m_axi_awvalid && (sw_hang != 1) && (aw_age > sw_aw_lat);
            aw_hs = m_axi_awvalid && m_axi_awready;
            if (aw_hs) begin
                if (awq.size() == 0) fail("aw_unexpected");
                else begin ex = awq.pop_front(); check("awaddr", m_axi_awaddr, ex); end
            end

            w_age = m_axi_wvalid ? w_age + 1 : 0;
            m_axi_wready = m_axi_wvalid && (sw_hang != 1) && (w_age > sw_w_lat);
            w_hs = m_axi_wvalid && m_axi_wready;
            if (w_hs) begin
                check("wstrb", 32'(m_axi_wstrb), 32'hf);
                if (wdq.size() == 0) fail("w_unexpected");
                else begin ex = wdq.pop_front(); check("wdata", m_axi_wdata, ex); end
            end

            b_age = m_axi_bready ? b_age + 1 : 0;
            m_axi_bvalid = m_axi_bready && (sw_hang == 0) && (b_age > sw_b_lat);
            m_axi_bresp  = m_axi_bvalid ? sw_bresp : 2'b00;
            b_hs = m_axi_bvalid && m_axi_bready;

            ar_age = m_axi_arvalid ? ar_age + 1 : 0;
            m_axi_arready = m_axi_arvalid && (sr_hang != 1) && (ar_age > sr_ar_lat);
            ar_hs = m_axi_arvalid && m_axi_arready;
            if (ar_hs) begin
                if (arq.size() == 0) fail("ar_unexpected");
                else begin ex = arq.pop_front(); check("araddr", m_axi_araddr, ex); end
            end

            r_age = m_axi_rready ? r_age + 1 : 0;
            m_axi_rvalid = m_axi_rready && (sr_hang == 0) && (r_age > sr_r_lat);
            m_axi_rdata  = m_axi_rvalid ? sr_rdata : $urandom;
            m_axi_rresp  = m_axi_rvalid ? sr_rresp : 2'b00;
            r_hs = m_axi_rvalid && m_axi_rready;
        end
    end

    // Ack monitor: pops the scoreboard whenever the DUT pulses an ack.
    logic wack_prev = 1'b0, rack_prev = 1'b0;
    always @(negedge up_clk) begin
        exp_t e;
        if (!up_rstn) begin
            wack_prev = 1'b0;
            rack_prev = 1'b0;
        end else begin
            if (up_wack) begin
                check("wack_single", 32'(wack_prev), 32'd0);
                check("w_chan_quiet_at_ack", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
                if (wq.size() == 0) fail("wack_unexpected");
                else begin
                    e = wq.pop_front();
                    check("wack_cycle", 32'(cyc), 32'(e.cyc));
                    check("werr", 32'(up_werr), 32'(e.err));
                end
                w_pending = 1'b0;
            end
            if (up_rack) begin
                check("rack_single", 32'(rack_prev), 32'd0);
                check("r_chan_quiet_at_ack", {30'd0, m_axi_arvalid, m_axi_rready}, 32'd0);
                if (rq.size() == 0) fail("rack_unexpected");
                else begin
                    e = rq.pop_front();
                    check("rack_cycle", 32'(cyc), 32'(e.cyc));
                    check("rerr", 32'(up_rerr), 32'(e.err));
                    check("rdata", up_rdata, e.data);
                end
                r_pending = 1'b0;
            end
            wack_prev = up_wack;
            rack_prev = up_rack;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {23'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                               m_axi_rready, up_wack, up_werr, up_rack, up_rerr}, 32'd0);
        check({tag, "_awaddr"}, m_axi_awaddr, 32'd0);
        check({tag, "_wdata"}, m_axi_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(m_axi_wstrb), 32'd0);
        check({tag, "_araddr"}, m_axi_araddr, 32'd0);
        check({tag, "_rdata"}, up_rdata, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge up_clk);
            up_wreq = 1'b0;
            up_rreq = 1'b0;
            n++;
        end while ((w_pending || r_pending) && n < budget);
        if (w_pending || r_pending) fail("wait_idle_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hang;
        repeat (3) @(negedge up_clk);
        check_outputs_zero("reset");
        up_rstn = 1'b1;

        // Zero-wait write.
        @(negedge up_clk);
        issue_write(8'h12, 32'hcafef00d, 0, 0, 0, 0, 2'b00);
        wait_idle(50);

        // Delayed handshakes: wready four cycles ahead of awready, B two cycles late.
        @(negedge up_clk);
        issue_write(8'h5c, 32'h01234567, 5, 1, 2, 0, 2'b00);
        wait_idle(50);

        // Read with SLVERR.
        @(negedge up_clk);
        issue_read(8'h03, 0, 0, 0, 32'h5a5a0001, 2'b10);
        wait_idle(50);

        // Timeout on both channels: no arready, no bvalid.
        @(negedge up_clk);
        issue_write(8'h21, 32'h11112222, 0, 0, 0, 2, 2'b00);
        issue_read(8'h44, 0, 0, 1, 32'h0, 2'b00);
        wait_idle(80);

        // Concurrent read and write, then a write request while the write is busy.
        @(negedge up_clk);
        issue_write(8'h7a, 32'h9abcdef0, 2, 3, 1, 0, 2'b01);
        issue_read(8'hb3, 0, 4, 0, 32'h600df00d, 2'b00);
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = 8'hee; up_wdata = 32'h0bad0bad;
        wait_idle(50);

        // Randomized traffic, including requests that must be dropped.
        for (int i = 0; i < 2500; i++) begin
            @(negedge up_clk);
            up_wreq = 1'b0;
            up_rreq = 1'b0;
            if (!w_pending && !up_wack) begin
                if ($urandom_range(0, 2) == 0) begin
                    hang = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
                    issue_write(AW'($urandom), $urandom, int'($urandom_range(0, 6)),
                                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), hang,
                                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
                end
            end else if ($urandom_range(0, 4) == 0) begin
                up_wreq = 1'b1; up_waddr = AW'($urandom); up_wdata = $urandom;
            end
            if (!r_pending && !up_rack) begin
                if ($urandom_range(0, 2) == 0) begin
                    hang = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
                    issue_read(AW'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                               hang, $urandom,
                               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
                end
            end else if ($urandom_range(0, 4) == 0) begin
                up_rreq = 1'b1; up_raddr = AW'($urandom);
            end
        end
        wait_idle(80);

        // Reset while the write waits for B and the read waits for arready.
        @(negedge up_clk);
        issue_write(8'h0f, 32'hfeedbeef, 0, 0, 0, 2, 2'b00);
        issue_read(8'h0e, 0, 0, 1, 32'h0, 2'b00);
        repeat (5) begin
            @(negedge up_clk);
            up_wreq = 1'b0;
            up_rreq = 1'b0;
        end
        check("pre_reset_bready", 32'(m_axi_bready), 32'd1);
        check("pre_reset_arvalid", 32'(m_axi_arvalid), 32'd1);
        #2 up_rstn = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge up_clk);
        wq.delete(); rq.delete(); awq.delete(); wdq.delete(); arq.delete();
        w_pending = 1'b0;
        r_pending = 1'b0;
        up_rstn = 1'b1;

        @(negedge up_clk);
        issue_write(8'h33, 32'h13572468, 1, 0, 1, 0, 2'b00);
        issue_read(8'h34, 1, 1, 0, 32'h24681357, 2'b00);
        wait_idle(50);

        repeat (3) @(negedge up_clk);
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("axi_q_drained", 32'(awq.size() + wdq.size() + arq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
